board_io_ctrl: RTL

Parametrised memory-mapped board I/O controller between the MIPS CPU data bus and the board switches, buttons, LEDs and multiplexed seven-segment display. It replaces direct wiring of sw/btn/seg/led with the following features:
- synchronised, debounced inputs
- sticky button-edge flags with write-1-to-clear
- software-writable LEDs
- a scanned N-digit hex display

Channel counts and timing constants are parameters, so the same block serves simulation and the board.

---
 rtl/board_io_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/board_io_ctrl.sv
// Memory-mapped board I/O controller: synchronised and debounced switches
// and buttons, sticky W1C button-edge flags, LEDs and a scanned hex display.
//
// Ports:
//   clk, rst_n       clock (rising edge), async active-low reset
//   addr, we, re     word address and one-cycle write/read strobes
//   wdata, rdata     write data in, registered read data out
//   sw, btn          raw asynchronous switch and button inputs
//   led              LED drive, written through the LED register
//   seg_an, seg_cat  active-low digit anodes and cathodes {dp,g..a}
//   irq              OR of all button edge flags
//
// Register map (word addresses; bits above the channel width read 0):
//   0 SW        RO   debounced switches
//   1 BTN_LEVEL RO   debounced buttons
//   2 BTN_EDGE  W1C  edge flags; a new rise beats a same-cycle clear
//   3 LED       RW
//   4 SEG       RW   digit k shows bits [4k+3:4k]
//   5 STATUS    RO   scan index in [3:0], irq in bit 8
//   6-7         read 0, writes ignored
module board_io_ctrl #(
    parameter int N_SW        = 8,
    parameter int N_BTN       = 4,
    parameter int N_LED       = 8,
    parameter int N_DIGITS    = 4,
    parameter int DB_CYCLES   = 4,
    parameter int SCAN_CYCLES = 4,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        addr,
    input  logic              we,
    input  logic              re,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic [N_SW-1:0]   sw,
    input  logic [N_BTN-1:0]  btn,
    output logic [N_LED-1:0]  led,
    output logic [N_DIGITS-1:0] seg_an,
    output logic [7:0]        seg_cat,
    output logic              irq
);

    localparam int N_IN  = N_SW + N_BTN;
    localparam int CW    = $clog2(DB_CYCLES);
    localparam int SCW   = (SCAN_CYCLES > 1) ?
                           $clog2(SCAN_CYCLES) : 1;
    localparam int IW    = (N_DIGITS > 1) ?
                           $clog2(N_DIGITS) : 1;
    localparam int SEG_W = 4 * N_DIGITS;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        logic [6:0] r;
        r = 7'h7F;
        unique case (d)
            4'h0: r = 7'h40;
            4'h1: r = 7'h79;
            4'h2: r = 7'h24;
            4'h3: r = 7'h30;
            4'h4: r = 7'h19;
            4'h5: r = 7'h12;
            4'h6: r = 7'h02;
            4'h7: r = 7'h78;
            4'h8: r = 7'h00;
            4'h9: r = 7'h10;
            4'hA: r = 7'h08;
            4'hB: r = 7'h03;
            4'hC: r = 7'h46;
            4'hD: r = 7'h21;
            4'hE: r = 7'h06;
            4'hF: r = 7'h0E;
        endcase
        return r;
    endfunction

    // Switches and buttons share one synchroniser/debouncer vector,
    // switches in the low bits.
    logic [N_IN-1:0] raw;
    logic [N_IN-1:0] sync1;
    logic [N_IN-1:0] sync2;
    logic [N_IN-1:0] stable;
    logic [N_IN-1:0] accept;
    logic [CW-1:0]   cnt [N_IN];

    assign raw = {btn, sw};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // A channel flips once its synchronised value has differed from
    // the stable value for DB_CYCLES consecutive cycles.
    always_comb begin
        accept = '0;
        for (int i = 0; i < N_IN; i++) begin
            accept[i] = (sync2[i] != stable[i]) &&
                        (cnt[i] == CW'(DB_CYCLES - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '0;
            for (int i = 0; i < N_IN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            stable <= stable ^ accept;
            for (int i = 0; i < N_IN; i++) begin
                if (sync2[i] == stable[i] || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    logic [N_SW-1:0]  sw_db;
    logic [N_BTN-1:0] btn_db;
    logic [N_BTN-1:0] btn_rise;

    assign sw_db    = stable[N_SW-1:0];
    assign btn_db   = stable[N_IN-1:N_SW];
    assign btn_rise = accept[N_IN-1:N_SW] & ~btn_db;

    logic wr_edge;
    logic wr_led;
    logic wr_seg;

    assign wr_edge = we && (addr == 3'd2);
    assign wr_led  = we && (addr == 3'd3);
    assign wr_seg  = we && (addr == 3'd4);

    logic [N_BTN-1:0] flag;
    logic [N_BTN-1:0] flag_clr;
    logic [N_BTN-1:0] flag_next;
    logic [SEG_W-1:0] seg_val;

    // Clear first, then set, so a rise in the clearing cycle survives.
    assign flag_clr  = wr_edge ? wdata[N_BTN-1:0] : '0;
    assign flag_next = (flag & ~flag_clr) | btn_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag    <= '0;
            irq     <= 1'b0;
            led     <= '0;
            seg_val <= '0;
        end else begin
            flag <= flag_next;
            irq  <= |flag_next;
            if (wr_led) begin
                led <= wdata[N_LED-1:0];
            end
            if (wr_seg) begin
                seg_val <= wdata[SEG_W-1:0];
            end
        end
    end

    logic wdata_unused;
    assign wdata_unused = ^wdata;

    logic [SCW-1:0] scan_cnt;
    logic [IW-1:0]  idx;
    logic           scan_wrap;
    logic [3:0]     digit;

    assign scan_wrap = (scan_cnt == SCW'(SCAN_CYCLES - 1));
    assign digit     = seg_val[{idx, 2'b00} +: 4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
            seg_an   <= ~N_DIGITS'(1);
            seg_cat  <= 8'hC0;
        end else begin
            if (scan_wrap) begin
                scan_cnt <= '0;
                if (idx == IW'(N_DIGITS - 1)) begin
                    idx <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            seg_an  <= ~(N_DIGITS'(1) << idx);
            seg_cat <= {1'b1, dec7(digit)};
        end
    end

    logic [DATA_W-1:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            addr == 3'd0: rd_mux[N_SW-1:0]  = sw_db;
            addr == 3'd1: rd_mux[N_BTN-1:0] = btn_db;
            addr == 3'd2: rd_mux[N_BTN-1:0] = flag;
            addr == 3'd3: rd_mux[N_LED-1:0] = led;
            addr == 3'd4: rd_mux[SEG_W-1:0] = seg_val;
            addr == 3'd5: begin
                rd_mux[IW-1:0] = idx;
                rd_mux[8]      = irq;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rd_mux;
        end
    end

endmodule
